fifo_wr_arbiter: RTL

//  Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters in the i_wr_clk domain.

---
 rtl/fifo_wr_arbiter_if.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the round-robin arbiter and the FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDW      = 2
);
  logic [NUM_REQ-1:0]          i_req;
  logic [NUM_REQ*DATASIZE-1:0] i_req_data;
  logic [NUM_REQ-1:0]          o_gnt;
  logic                        i_full;
  logic                        o_wr_en;
  logic [DATASIZE-1:0]         o_wr_data;
  logic [IDW-1:0]              o_wr_src;
  logic [15:0]                 o_stall_cnt;

  modport master (
    output i_req, i_req_data, i_full,
    input  o_gnt, o_wr_en, o_wr_data, o_wr_src, o_stall_cnt
  );

  modport slave (
    input  i_req, i_req_data, i_full,
    output o_gnt, o_wr_en, o_wr_data, o_wr_src, o_stall_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the async FIFO write port with zero-latency grant and full-stall counter.
// Optional burst lock (up to BURST_LEN beats per grant) is enabled by defining ARB_BURST_LOCK_EN.
module fifo_wr_arbiter #(
  parameter int unsigned DATASIZE  = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDW       = 2,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              i_wr_clk,
  input  logic              i_wr_rst_n,
  fifo_wr_arbiter_if.slave  bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDW) < NUM_REQ ||
      BURST_LEN < 1 || BURST_LEN > 16) begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of range");
  end

  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      rr_ptr_n;
  logic [IDW-1:0]      arb_idx;
  logic                arb_found;
  logic [IDW-1:0]      win_idx;
  logic                win_vld;
  logic                gnt_fire;
  logic [DATASIZE-1:0] wr_data;
  logic [15:0]         stall_cnt;

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
    return (p == IDW'(NUM_REQ - 1)) ? '0 : p + IDW'(1);
  endfunction

  always_comb begin : rr_scan
    logic [IDW-1:0] k;
    arb_found = 1'b0;
    arb_idx   = '0;
    k         = rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && bus.i_req[k]) begin
        arb_found = 1'b1;
        arb_idx   = k;
      end
      k = ptr_inc(k);
    end
  end

`ifdef ARB_BURST_LOCK_EN
  typedef enum logic {ARB, LOCK} state_t;

  state_t         state;
  state_t         state_n;
  logic [3:0]     beat_cnt;
  logic [3:0]     beat_cnt_n;
  logic [IDW-1:0] lock_idx;
  logic [IDW-1:0] lock_idx_n;
  logic           lock_hold;

  // rr_ptr already sits at locked+1 during a lock, so a dropped lock re-arbitrates in the same cycle.
  assign lock_hold = (state == LOCK) && bus.i_req[lock_idx];
  assign win_idx   = lock_hold ? lock_idx : arb_idx;
  assign win_vld   = lock_hold | arb_found;

  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      state    <= ARB;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
      lock_idx <= lock_idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    lock_idx_n = lock_idx;
    if (gnt_fire) begin
      rr_ptr_n = ptr_inc(win_idx);
      if (lock_hold) begin
        if (({1'b0, beat_cnt} + 5'd1) >= 5'(BURST_LEN)) begin
          state_n    = ARB;
          beat_cnt_n = '0;
        end else begin
          beat_cnt_n = beat_cnt + 4'd1;
        end
      end else if (BURST_LEN > 1) begin
        state_n    = LOCK;
        lock_idx_n = win_idx;
        beat_cnt_n = 4'd1;
      end else begin
        state_n    = ARB;
        beat_cnt_n = '0;
      end
    end else if (!bus.i_full && state == LOCK && !lock_hold) begin
      state_n    = ARB;
      beat_cnt_n = '0;
    end
  end
`else
  assign win_idx = arb_idx;
  assign win_vld = arb_found;

  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr_n;
    end
  end

  always_comb begin
    rr_ptr_n = rr_ptr;
    if (gnt_fire) begin
      rr_ptr_n = ptr_inc(win_idx);
    end
  end
`endif

  always_comb begin
    wr_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDW'(k)) begin
        wr_data = bus.i_req_data[k*DATASIZE +: DATASIZE];
      end
    end
  end

  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      stall_cnt <= '0;
    end else if (|bus.i_req && bus.i_full && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Reset gates the grant directly so nothing is accepted while i_wr_rst_n is low.
  assign gnt_fire        = win_vld & ~bus.i_full & i_wr_rst_n;
  assign bus.o_gnt       = gnt_fire ? (NUM_REQ'(1) << win_idx) : '0;
  assign bus.o_wr_en     = gnt_fire;
  assign bus.o_wr_data   = wr_data;
  assign bus.o_wr_src    = win_idx;
  assign bus.o_stall_cnt = stall_cnt;

endmodule
